// File: rtl/id_ex_stage.sv
// RV32I decode stage with the ID/EX pipeline register.
// Drives register-file read addresses, builds the immediate, detects
// load-use hazards against EX and inserts a bubble when one is found.
module id_ex_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        valid_d,
  input  logic        flush_e,
  output logic [4:0]  a1_d,
  output logic [4:0]  a2_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  output logic        stall_fd,
  output logic        valid_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic [6:0]  opcode_e,
  output logic [2:0]  funct3_e,
  output logic        funct7b5_e,
  output logic        reg_write_e,
  output logic        is_load_e,
  output logic        illegal_e
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        uses_rs1, uses_rs2, writes_rd, known, is_load;
  logic        hazard;

  assign opcode = instr_d[6:0];
  assign rd     = instr_d[11:7];
  assign funct3 = instr_d[14:12];
  assign rs1    = instr_d[19:15];
  assign rs2    = instr_d[24:20];
  assign a1_d   = rs1;
  assign a2_d   = rs2;

  // Opcode class decode and immediate generation.
  always_comb begin
    imm       = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    known     = 1'b1;
    is_load   = 1'b0;
    unique case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
      end
      OP_IALU: begin
        imm = {{20{instr_d[31]}}, instr_d[31:20]};
        uses_rs1 = 1'b1; writes_rd = 1'b1;
      end
      OP_LOAD: begin
        imm = {{20{instr_d[31]}}, instr_d[31:20]};
        uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1;
      end
      OP_JALR: begin
        imm = {{20{instr_d[31]}}, instr_d[31:20]};
        uses_rs1 = 1'b1; writes_rd = 1'b1;
      end
      OP_STORE: begin
        imm = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BR: begin
        imm = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        imm = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm = {instr_d[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // Load-use: the load in EX has no data until MEM, so a dependent op in ID must wait one cycle.
  always_comb begin
    hazard = valid_e & is_load_e & (rd_e != 5'd0) & valid_d &
             ((uses_rs1 & (rs1 == rd_e)) | (uses_rs2 & (rs2 == rd_e)));
    // A flush discards IF/ID anyway, so holding it would be pointless.
    stall_fd = hazard & ~flush_e;
  end

  // ID/EX register: reset > flush > hazard bubble > normal capture.
  always_ff @(posedge clk) begin
    if (rst || flush_e || hazard) begin
      valid_e     <= 1'b0;
      pc_e        <= '0;
      pc_plus4_e  <= '0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_e       <= '0;
      rs1_e       <= NOP_INSTR[19:15];
      rs2_e       <= NOP_INSTR[24:20];
      rd_e        <= NOP_INSTR[11:7];
      opcode_e    <= NOP_INSTR[6:0];
      funct3_e    <= NOP_INSTR[14:12];
      funct7b5_e  <= NOP_INSTR[30];
      reg_write_e <= 1'b0;
      is_load_e   <= 1'b0;
      illegal_e   <= 1'b0;
    end else begin
      valid_e     <= valid_d;
      pc_e        <= pc_d;
      pc_plus4_e  <= pc_plus4_d;
      rd1_e       <= rd1_d;
      rd2_e       <= rd2_d;
      imm_e       <= imm;
      rs1_e       <= rs1;
      rs2_e       <= rs2;
      rd_e        <= rd;
      opcode_e    <= opcode;
      funct3_e    <= funct3;
      funct7b5_e  <= instr_d[30];
      reg_write_e <= writes_rd & (rd != 5'd0) & valid_d;
      is_load_e   <= is_load & valid_d;
      illegal_e   <= ~known & valid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, immediates, load-use stall,
// flush priority, x0 loads, illegal opcodes and mid-stream reset.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d, pc_d, pc_plus4_d, rd1_d, rd2_d;
  logic        valid_d, flush_e;
  logic [4:0]  a1_d, a2_d;
  logic        stall_fd, valid_e;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [6:0]  opcode_e;
  logic [2:0]  funct3_e;
  logic        funct7b5_e, reg_write_e, is_load_e, illegal_e;

  int errs = 0;
  int nchk = 0;

  localparam logic [31:0] ADDI_M1 = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] BEQ_M4  = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] LUI     = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] LW_X6   = 32'h0000A303; // lw x6,0(x1)
  localparam logic [31:0] ADD_DEP = 32'h002303B3; // add x7,x6,x2
  localparam logic [31:0] ADD_IND = 32'h003103B3; // add x7,x2,x3
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_X0  = 32'h000003B3; // add x7,x0,x0
  localparam logic [31:0] ILLEGAL = 32'h0000007F;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .flush_e(flush_e), .a1_d(a1_d), .a2_d(a2_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .stall_fd(stall_fd), .valid_e(valid_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .opcode_e(opcode_e), .funct3_e(funct3_e), .funct7b5_e(funct7b5_e),
    .reg_write_e(reg_write_e), .is_load_e(is_load_e), .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic fl);
    instr_d    = ins;
    valid_d    = v;
    flush_e    = fl;
    pc_d       = pc_d + 32'd4;
    pc_plus4_d = pc_d + 32'd4;
  endtask

  // advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_d = ADDI_M1; valid_d = 1'b1; flush_e = 1'b0;
    pc_d = 32'h100; pc_plus4_d = 32'h104; rd1_d = 32'h0; rd2_d = 32'h0;
    tick(); tick();
    chk("rst valid_e", valid_e, 0);
    chk("rst reg_write_e", reg_write_e, 0);
    chk("rst imm_e", imm_e, 0);
    chk("rst stall_fd", stall_fd, 0);
    chk("rst opcode_e", opcode_e, 7'h13);
    rst = 1'b0;

    // I-type immediate
    drive(ADDI_M1, 1, 0); rd1_d = 32'hA5A5_0001; rd2_d = 32'h5A5A_0002;
    #1 chk("addi a1_d", a1_d, 0);
    tick();
    chk("addi imm_e", imm_e, 32'hFFFF_FFFF);
    chk("addi rd_e", rd_e, 5);
    chk("addi rs1_e", rs1_e, 0);
    chk("addi reg_write_e", reg_write_e, 1);
    chk("addi valid_e", valid_e, 1);
    chk("addi rd1_e", rd1_e, 32'hA5A5_0001);
    chk("addi pc_e", pc_e, 32'h104);
    chk("addi pc_plus4_e", pc_plus4_e, 32'h108);

    // B-type and U-type immediates
    drive(BEQ_M4, 1, 0); tick();
    chk("beq imm_e", imm_e, 32'hFFFF_FFFC);
    chk("beq reg_write_e", reg_write_e, 0);
    drive(LUI, 1, 0); tick();
    chk("lui imm_e", imm_e, 32'h1234_5000);
    chk("lui reg_write_e", reg_write_e, 1);

    // Load-use: one stall cycle, one bubble, then the add
    drive(LW_X6, 1, 0); tick();
    chk("lw is_load_e", is_load_e, 1);
    drive(ADD_DEP, 1, 0);
    #1 chk("lu stall_fd", stall_fd, 1);
    tick();
    chk("lu bubble valid_e", valid_e, 0);
    chk("lu bubble opcode_e", opcode_e, 7'h13);
    chk("lu stall released", stall_fd, 0);
    tick();
    chk("lu add valid_e", valid_e, 1);
    chk("lu add rs1_e", rs1_e, 6);
    chk("lu add rs2_e", rs2_e, 2);
    chk("lu add rd_e", rd_e, 7);

    // Independent add after load: no stall
    drive(LW_X6, 1, 0); tick();
    drive(ADD_IND, 1, 0);
    #1 chk("indep stall_fd", stall_fd, 0);
    tick();
    chk("indep valid_e", valid_e, 1);

    // Flush in hazard cycle: no stall, bubble
    drive(LW_X6, 1, 0); tick();
    drive(ADD_DEP, 1, 1);
    #1 chk("flush stall_fd", stall_fd, 0);
    tick();
    chk("flush valid_e", valid_e, 0);
    chk("flush reg_write_e", reg_write_e, 0);
    flush_e = 1'b0;

    // lw x0 never stalls
    drive(LW_X0, 1, 0); tick();
    chk("lw x0 is_load_e", is_load_e, 1);
    drive(ADD_X0, 1, 0);
    #1 chk("x0 stall_fd", stall_fd, 0);
    tick();

    // Illegal opcode
    drive(ILLEGAL, 1, 0); tick();
    chk("illegal illegal_e", illegal_e, 1);
    chk("illegal reg_write_e", reg_write_e, 0);
    chk("illegal imm_e", imm_e, 0);

    // valid_d=0 qualifies control bits
    drive(LW_X6, 0, 0); tick();
    chk("invalid valid_e", valid_e, 0);
    chk("invalid is_load_e", is_load_e, 0);
    chk("invalid reg_write_e", reg_write_e, 0);

    // Reset mid-stream during a hazard
    drive(LW_X6, 1, 0); tick();
    drive(ADD_DEP, 1, 0); rst = 1'b1;
    tick();
    chk("midrst valid_e", valid_e, 0);
    chk("midrst stall_fd", stall_fd, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
